mux_scan_sequencer: RTL

//  Upstream driver and sampler for the 16:1 (4:1-tree) mux.
//  - Latches a 16-bit word and presents it on the mux data inputs.
//  - Sweeps the mux select 0..15 and samples the mux output after a settle delay.
//  - Emits the sampled bits as a serial stream and as a reassembled 16-bit word.
//  - Used for lab bring-up: proves every mux path end to end.

---
 rtl/mux_scan_sequencer_pkg.sv | 25 ++
 rtl/mux_scan_sequencer_scan_sel_counter.sv | 56 +++++
 rtl/mux_scan_sequencer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/mux_scan_sequencer_pkg.sv
// Shared definitions for the mux scan sequencer: FSM state encodings, word and
// counter widths, and the counter control bundle passed between FSM and counter.
package mux_scan_sequencer_pkg;

  localparam int MUX_W = 16;
  localparam int SEL_W = 4;
  localparam int CNT_W = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  typedef struct packed {
    logic clr;
    logic cnt_en;
    logic sel_inc;
  } cnt_ctrl_t;

  // Value the settle counter holds in the last settle cycle before sampling.
  function automatic logic [CNT_W-1:0] settle_last(input int settle);
    return CNT_W'(settle - 1);
  endfunction

endpackage

// File: rtl/mux_scan_sequencer_scan_sel_counter.sv
// Settle-delay counter and mux select counter for the scan sequencer, with the
// terminal-count flags the FSM branches on.
module scan_sel_counter
  import mux_scan_sequencer_pkg::*;
#(
  parameter int SEL_W  = 4,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             cnt_en,
  input  logic             sel_inc,
  output logic [SEL_W-1:0] sel,
  output logic             settle_tc,
  output logic             last_sel
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] sel_d;

  // Advancing the select also restarts the settle delay for the new path.
  always_comb begin
    cnt_d = cnt_q;
    sel_d = sel_q;
    if (clr) begin
      cnt_d = '0;
      sel_d = '0;
    end else begin
      if (cnt_en) begin
        cnt_d = cnt_q + 1'b1;
      end
      if (sel_inc) begin
        sel_d = sel_q + 1'b1;
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      sel_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      sel_q <= sel_d;
    end
  end

  assign sel       = sel_q;
  assign settle_tc = (cnt_q == settle_last(SETTLE));
  assign last_sel  = &sel_q;

endmodule

// File: rtl/mux_scan_sequencer.sv
// Drives a 16:1 mux with a latched word, sweeps its select and reassembles the
// sampled output. Optional end-of-scan self-compare enabled by MUX_SCAN_CHECK_EN.
module mux_scan_sequencer
  import mux_scan_sequencer_pkg::*;
#(
  parameter int SEL_W  = 4,
  parameter int SETTLE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [(1<<SEL_W)-1:0]   data_in,
  output logic [0:(1<<SEL_W)-1]   mux_w,
  output logic [SEL_W-1:0]        mux_s,
  input  logic                    mux_f,
  output logic                    ser_out,
  output logic                    ser_valid,
  output logic [0:(1<<SEL_W)-1]   result,
  output logic                    busy,
  output logic                    done,
  output logic                    mismatch
);

  localparam int WORD_W = 1 << SEL_W;

  logic [1:0]          state_q;
  logic [1:0]          state_d;
  logic [0:WORD_W-1]   mux_w_q;
  logic [0:WORD_W-1]   mux_w_d;
  logic [0:WORD_W-1]   result_q;
  logic [0:WORD_W-1]   result_d;
  logic                ser_out_q;
  logic                ser_out_d;
  logic                ser_valid_q;
  logic                ser_valid_d;
  logic                busy_q;
  logic                busy_d;
  logic                done_q;
  logic                done_d;

  cnt_ctrl_t           ctrl;
  logic [SEL_W-1:0]    sel;
  logic                settle_tc;
  logic                last_sel;

  scan_sel_counter #(
    .SEL_W  (SEL_W),
    .SETTLE (SETTLE)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (ctrl.clr),
    .cnt_en    (ctrl.cnt_en),
    .sel_inc   (ctrl.sel_inc),
    .sel       (sel),
    .settle_tc (settle_tc),
    .last_sel  (last_sel)
  );

`ifdef MUX_SCAN_CHECK_EN
  logic mismatch_q;
  logic mismatch_d;
`endif

  // done is registered on the SAMPLE->DONE edge so it is high exactly in DONE.
  always_comb begin
    state_d     = state_q;
    mux_w_d     = mux_w_q;
    result_d    = result_q;
    ser_out_d   = ser_out_q;
    ser_valid_d = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    ctrl        = '0;
`ifdef MUX_SCAN_CHECK_EN
    mismatch_d  = mismatch_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mux_w_d  = data_in;
          busy_d   = 1'b1;
          ctrl.clr = 1'b1;
          state_d  = ST_SETTLE;
`ifdef MUX_SCAN_CHECK_EN
          mismatch_d = 1'b0;
`endif
        end
      end
      ST_SETTLE: begin
        ctrl.cnt_en = 1'b1;
        if (settle_tc) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        result_d[sel] = mux_f;
        ser_out_d     = mux_f;
        ser_valid_d   = 1'b1;
        if (last_sel) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          ctrl.sel_inc = 1'b1;
          state_d      = ST_SETTLE;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
`ifdef MUX_SCAN_CHECK_EN
        // result_q already holds the final bit written by the preceding SAMPLE.
        mismatch_d = (result_q != mux_w_q);
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mux_w_q     <= '0;
      result_q    <= '0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mux_w_q     <= mux_w_d;
      result_q    <= result_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

`ifdef MUX_SCAN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch_q <= 1'b0;
    end else begin
      mismatch_q <= mismatch_d;
    end
  end

  assign mismatch = mismatch_q;
`else
  assign mismatch = 1'b0;
`endif

  assign mux_w     = mux_w_q;
  assign mux_s     = sel;
  assign result    = result_q;
  assign ser_out   = ser_out_q;
  assign ser_valid = ser_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
